// File: rtl/cnn_layer_accel_pkg.sv
// cnn_layer_accel_pkg
// Shared definitions for the convolution-engine accelerator blocks.
// Holds the default datapath widths, the signed activation saturation
// limits and the record carried between the round and saturate stages
// of the MACC output conditioning pipeline.
package cnn_layer_accel_pkg;

    localparam int C_P_WIDTH     = 48;
    localparam int C_OUT_WIDTH   = 16;
    localparam int C_SHIFT_WIDTH = 6;

    // Largest and smallest representable signed activation values.
    localparam longint C_SAT_MAX = (longint'(1) <<< (C_OUT_WIDTH - 1)) - 1;
    localparam longint C_SAT_MIN = -(longint'(1) <<< (C_OUT_WIDTH - 1));

    // One guard bit above the P width, so adding the rounding constant can
    // never wrap even for the most positive P value.
    typedef struct packed {
        logic                        valid;
        logic signed [C_P_WIDTH:0]   value;
        logic [C_SHIFT_WIDTH-1:0]    shift;
    } macc_pipe_t;

endpackage

// File: rtl/cnn_layer_accel_sync_fifo.sv
// cnn_layer_accel_sync_fifo
// Parameterised synchronous first-word-fall-through FIFO. The head entry is
// presented on rd_data whenever the FIFO is non-empty; rd_data reads zero
// when empty. A write into a full FIFO is still accepted when a pop happens
// in the same cycle.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   wr_en         write request
//   wr_data       data to store
//   rd_en         pop request (ignored while empty)
//   rd_data       head entry
//   full, empty   occupancy flags
//   count         number of stored entries
module cnn_layer_accel_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array; no reset needed because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cnn_layer_accel_ce_macc_out.sv
// cnn_layer_accel_ce_macc_out
// Output conditioning for the DSP48E2 MACC chain tail. Captures P when
// valid, adds a round-half-up constant, arithmetic-shifts right by the
// runtime cfg_shift, saturates to a signed activation and queues the
// result in a small FWFT FIFO toward write-back.
// Optional build macro: CNN_LAYER_ACCEL_MACC_OUT_RELU_EN clamps negative
// results to zero before saturation.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   p_in, p_valid MACC result and its valid strobe
//   cfg_shift     right-shift amount sampled with p_valid
//   clr_status    clears ovf_sticky / sat_sticky (a same-cycle set wins)
//   dout, dout_valid, dout_ready   FIFO head with valid/ready handshake
//   fifo_count    FIFO occupancy
//   p_afull       occupancy plus in-flight results reached DEPTH-1
//   ovf_sticky    a result was dropped on a full FIFO
//   sat_sticky    a result saturated
module cnn_layer_accel_ce_macc_out #(
    parameter int C_P_WIDTH     = cnn_layer_accel_pkg::C_P_WIDTH,
    parameter int C_OUT_WIDTH   = cnn_layer_accel_pkg::C_OUT_WIDTH,
    parameter int C_SHIFT_WIDTH = cnn_layer_accel_pkg::C_SHIFT_WIDTH,
    parameter int C_FIFO_DEPTH  = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic signed [C_P_WIDTH-1:0]             p_in,
    input  logic                                    p_valid,
    input  logic [C_SHIFT_WIDTH-1:0]                cfg_shift,
    input  logic                                    clr_status,
    output logic signed [C_OUT_WIDTH-1:0]           dout,
    output logic                                    dout_valid,
    input  logic                                    dout_ready,
    output logic [$clog2(C_FIFO_DEPTH+1)-1:0]       fifo_count,
    output logic                                    p_afull,
    output logic                                    ovf_sticky,
    output logic                                    sat_sticky
);

    import cnn_layer_accel_pkg::*;

    localparam int CW = $clog2(C_FIFO_DEPTH + 1);

    logic                       s1_valid;
    logic signed [C_P_WIDTH-1:0] s1_p;
    logic [C_SHIFT_WIDTH-1:0]   s1_shift;
    macc_pipe_t                 s2;

    logic signed [C_P_WIDTH:0]  round_add;
    logic signed [C_P_WIDTH:0]  round_sum;
    logic signed [C_P_WIDTH:0]  s2_value;
    logic signed [C_P_WIDTH:0]  shifted;
    logic signed [C_P_WIDTH:0]  clamped;
    logic [C_OUT_WIDTH-1:0]     sat_val;
    logic                       sat_hit;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       sat_event;
    logic                       ovf_event;
    logic [CW:0]                occupancy;

    // Stage 1: capture the chain tail result and its shift amount.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_shift <= '0;
        end else begin
            s1_valid <= p_valid;
            if (p_valid) begin
                s1_p     <= p_in;
                s1_shift <= cfg_shift;
            end
        end
    end

    // Round-half-up: add half an output LSB before the arithmetic shift.
    always_comb begin
        round_add = '0;
        if (s1_shift != '0) begin
            round_add = (C_P_WIDTH + 1)'(1) << (s1_shift - 1'b1);
        end
        round_sum = {s1_p[C_P_WIDTH-1], s1_p} + round_add;
    end

    // Stage 2: hold the rounded sum together with the shift still to apply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2 <= '0;
        end else begin
            s2.valid <= s1_valid;
            s2.value <= round_sum;
            s2.shift <= s1_shift;
        end
    end

    // Stage 3: shift, optional ReLU, then saturate to the activation width.
    always_comb begin
        s2_value = s2.value;
        shifted  = s2_value >>> s2.shift;
`ifdef CNN_LAYER_ACCEL_MACC_OUT_RELU_EN
        clamped  = shifted[C_P_WIDTH] ? '0 : shifted;
`else
        clamped  = shifted;
`endif
        sat_hit  = 1'b0;
        sat_val  = clamped[C_OUT_WIDTH-1:0];
        if (longint'(clamped) > C_SAT_MAX) begin
            sat_val = C_OUT_WIDTH'(C_SAT_MAX);
            sat_hit = 1'b1;
        end else if (longint'(clamped) < C_SAT_MIN) begin
            sat_val = C_OUT_WIDTH'(C_SAT_MIN);
            sat_hit = 1'b1;
        end
    end

    cnn_layer_accel_sync_fifo #(
        .WIDTH (C_OUT_WIDTH),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s2.valid),
        .wr_data (sat_val),
        .rd_en   (dout_ready),
        .rd_data (dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign dout_valid = !fifo_empty;

    // A full FIFO is never empty, so a pop there depends only on dout_ready.
    assign sat_event = s2.valid && sat_hit;
    assign ovf_event = s2.valid && fifo_full && !dout_ready;

    assign occupancy = {1'b0, fifo_count} + (CW + 1)'(s1_valid) + (CW + 1)'(s2.valid);
    assign p_afull   = (occupancy >= (CW + 1)'(C_FIFO_DEPTH - 1));

    // Sticky status flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            sat_sticky <= 1'b0;
        end else begin
            if (ovf_event) begin
                ovf_sticky <= 1'b1;
            end else if (clr_status) begin
                ovf_sticky <= 1'b0;
            end
            if (sat_event) begin
                sat_sticky <= 1'b1;
            end else if (clr_status) begin
                sat_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_ce_macc_out.sv
// tb_cnn_layer_accel_ce_macc_out
// Directed bench for the MACC output conditioning stage: a table of
// {p, shift, expected activation, expected saturation} records exercised
// one at a time, plus hand-written sequences for throughput, FIFO
// overflow with almost-full, and asynchronous reset.
module tb_cnn_layer_accel_ce_macc_out;

    localparam int C_FIFO_DEPTH = 4;

`ifdef CNN_LAYER_ACCEL_MACC_OUT_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic signed [47:0] p_in;
    logic               p_valid;
    logic [5:0]         cfg_shift;
    logic               clr_status;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               dout_ready;
    logic [2:0]         fifo_count;
    logic               p_afull;
    logic               ovf_sticky;
    logic               sat_sticky;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        logic signed [47:0] p;
        logic [5:0]         shift;
        logic signed [15:0] exp_dout;
        logic               exp_sat;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vectors [NVEC];

    always #5 clk = ~clk;

    cnn_layer_accel_ce_macc_out #(
        .C_FIFO_DEPTH (C_FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_in       (p_in),
        .p_valid    (p_valid),
        .cfg_shift  (cfg_shift),
        .clr_status (clr_status),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_count (fifo_count),
        .p_afull    (p_afull),
        .ovf_sticky (ovf_sticky),
        .sat_sticky (sat_sticky)
    );

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Present one MACC result for a single cycle; returns at the negedge
    // right after the capturing edge.
    task automatic applyStimulus(input logic signed [47:0] p, input logic [5:0] shift);
        @(negedge clk);
        p_in      = p;
        cfg_shift = shift;
        p_valid   = 1'b1;
        @(negedge clk);
        p_valid   = 1'b0;
    endtask

    // One-cycle pulse of the status clear.
    task automatic applyClear();
        @(negedge clk);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors[0]  = '{48'sd1000,        6'd4,  16'sd63,                    1'b0};
        vectors[1]  = '{-48'sd1000,       6'd4,  RELU ? 16'sd0 : -16'sd62,    1'b0};
        vectors[2]  = '{48'sd1048576,     6'd4,  16'sd32767,                 1'b1};
        vectors[3]  = '{-48'sd40000,      6'd0,  RELU ? 16'sd0 : -16'sd32768, !RELU};
        vectors[4]  = '{48'sd7,           6'd1,  16'sd4,                     1'b0};
        vectors[5]  = '{-48'sd7,          6'd1,  RELU ? 16'sd0 : -16'sd3,     1'b0};
        vectors[6]  = '{48'sd32767,       6'd0,  16'sd32767,                 1'b0};
        vectors[7]  = '{48'sd32768,       6'd0,  16'sd32767,                 1'b1};
        vectors[8]  = '{-48'sd32768,      6'd0,  RELU ? 16'sd0 : -16'sd32768, 1'b0};
        vectors[9]  = '{-48'sd32769,      6'd0,  RELU ? 16'sd0 : -16'sd32768, !RELU};
        vectors[10] = '{48'sd24,          6'd4,  16'sd2,                     1'b0};
        vectors[11] = '{48'sd23,          6'd4,  16'sd1,                     1'b0};
        vectors[12] = '{-48'sd8,          6'd4,  16'sd0,                     1'b0};
        vectors[13] = '{-48'sd24,         6'd4,  RELU ? 16'sd0 : -16'sd1,     1'b0};
        vectors[14] = '{48'sh7FFFFFFFFFFF, 6'd47, 16'sd1,                    1'b0};
        vectors[15] = '{48'sh800000000000, 6'd47, RELU ? 16'sd0 : -16'sd1,   1'b0};
        vectors[16] = '{48'sd1073741824,  6'd16, 16'sd16384,                 1'b0};
        vectors[17] = '{-48'sd1048576,    6'd4,  RELU ? 16'sd0 : -16'sd32768, !RELU};

        rst        = 1'b1;
        p_in       = '0;
        p_valid    = 1'b0;
        cfg_shift  = '0;
        clr_status = 1'b0;
        dout_ready = 1'b1;

        #1;
        checkOutput("reset_dout",       dout,       0);
        checkOutput("reset_dout_valid", dout_valid, 0);
        checkOutput("reset_fifo_count", fifo_count, 0);
        checkOutput("reset_p_afull",    p_afull,    0);
        checkOutput("reset_ovf_sticky", ovf_sticky, 0);
        checkOutput("reset_sat_sticky", sat_sticky, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table-driven single results with exact three-cycle latency.
        for (int i = 0; i < NVEC; i++) begin
            applyClear();
            checkOutput($sformatf("vec%0d_clear_sat", i), sat_sticky, 0);
            checkOutput($sformatf("vec%0d_idle", i), dout_valid, 0);
            applyStimulus(vectors[i].p, vectors[i].shift);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_early", i), dout_valid, 0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_valid", i), dout_valid, 1);
            checkOutput($sformatf("vec%0d_dout", i), dout, vectors[i].exp_dout);
            checkOutput($sformatf("vec%0d_sat", i), sat_sticky, vectors[i].exp_sat);
        end
        applyClear();

        // Back-to-back results stream out one per cycle.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            p_in      = 48'sd10 + 48'(k);
            cfg_shift = 6'd0;
            p_valid   = 1'b1;
        end
        @(negedge clk);
        p_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("stream%0d_valid", k), dout_valid, 1);
            checkOutput($sformatf("stream%0d_dout", k), dout, 10 + k);
            @(negedge clk);
        end
        checkOutput("stream_drained", dout_valid, 0);

        // Overflow: six results into a blocked four-entry FIFO.
        dout_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1 || i == 2) checkOutput($sformatf("afull_low%0d", i), p_afull, 0);
            if (i == 3) checkOutput("afull_high", p_afull, 1);
            p_in      = 48'sd16 * 48'(i + 1);
            cfg_shift = 6'd4;
            p_valid   = 1'b1;
        end
        @(negedge clk);
        p_valid = 1'b0;
        checkOutput("ovf_count_full", fifo_count, 4);
        checkOutput("ovf_not_yet",    ovf_sticky, 0);
        @(negedge clk);
        checkOutput("ovf_set",        ovf_sticky, 1);
        @(negedge clk);
        checkOutput("ovf_count_hold", fifo_count, 4);
        checkOutput("ovf_afull",      p_afull,    1);
        checkOutput("ovf_head_hold",  dout,       1);
        checkOutput("ovf_sat_clean",  sat_sticky, 0);
        dout_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("drain%0d_valid", k), dout_valid, 1);
            checkOutput($sformatf("drain%0d_dout", k), dout, k);
            @(negedge clk);
        end
        checkOutput("drain_empty", dout_valid, 0);
        checkOutput("drain_count", fifo_count, 0);
        applyClear();
        checkOutput("ovf_cleared", ovf_sticky, 0);

        // Asynchronous reset with two entries buffered.
        dout_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            p_in      = 48'sd5000;
            cfg_shift = 6'd0;
            p_valid   = 1'b1;
        end
        @(negedge clk);
        p_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("prereset_count", fifo_count, 2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset_valid", dout_valid, 0);
        checkOutput("midreset_count", fifo_count, 0);
        checkOutput("midreset_dout",  dout,       0);
        checkOutput("midreset_afull", p_afull,    0);
        @(negedge clk);
        rst        = 1'b0;
        dout_ready = 1'b1;
        applyStimulus(48'sd1000, 6'd4);
        @(negedge clk);
        checkOutput("postreset_early", dout_valid, 0);
        @(negedge clk);
        checkOutput("postreset_valid", dout_valid, 1);
        checkOutput("postreset_dout",  dout,       63);
        @(negedge clk);
        checkOutput("postreset_count", fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/cnn_layer_accel_ce_macc_out.md
# cnn_layer_accel_ce_macc_out

Output conditioning stage directly downstream of the convolution-engine DSP48E2 MACC chain. Captures the 48-bit P result of the chain tail when flagged valid, then applies a runtime fixed-point right shift with round-half-up and saturates to a signed 16-bit activation. Results are buffered in a small first-word-fall-through FIFO with a valid/ready handshake toward the output write-back logic. The MACC chain cannot stall, so the block reports almost-full to the sequencer and flags any dropped results.

## Interface
- C_P_WIDTH, 48: MACC P width.
- C_OUT_WIDTH, 16: activation width.
- C_SHIFT_WIDTH, 6: width of cfg_shift.
- C_FIFO_DEPTH, 4: FIFO entries, power of two, ≥4.
- CLK  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- p_in  in  C_P_WIDTH  signed MACC result.
- p_valid  in  1  p_in valid this cycle.
- cfg_shift  in  C_SHIFT_WIDTH  right-shift amount, 0..47, sampled with p_valid.
- clr_status  in  1  synchronous clear of the sticky flags.
- dout  out  C_OUT_WIDTH  signed activation, FIFO head.
- dout_valid  out  1  FIFO non-empty.
- dout_ready  in  1  consumer accepts head.
- fifo_count  out  $clog2(C_FIFO_DEPTH+1)  occupancy.
- p_afull  out  1  FIFO occupancy plus in-flight results ≥ C_FIFO_DEPTH-1.
- ovf_sticky  out  1  a result was dropped because the FIFO was full.
- sat_sticky  out  1  a result saturated.

## Operation
- Stage 1 (capture): on p_valid, register p_in, cfg_shift and the valid bit.
- Stage 2 (round/shift): sum = sext49(p) + (shift==0 ? 0 : 1<<(shift-1)); r = sum >>> shift. 49-bit intermediate; sum never wraps.
- Stage 3 (saturate): r > 32767 → 32767; r < −32768 → −32768; both set sat_sticky. Otherwise truncate to C_OUT_WIDTH.
- FIFO write at end of stage 3. The write is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- A write that is not accepted drops the result and sets ovf_sticky. No other state changes.
- Pop occurs when dout_valid && dout_ready. dout_ready with the FIFO empty has no effect.
- Same-cycle push and pop leave fifo_count unchanged. Read and write pointers wrap modulo C_FIFO_DEPTH.
- clr_status clears both sticky flags. A set event in the same cycle wins over the clear.
- In-flight count = number of valid bits in stages 1–3. p_afull is combinational from registers only.

## Timing
- Reset values: dout=0, dout_valid=0, fifo_count=0, p_afull=0, ovf_sticky=0, sat_sticky=0. Pipeline valid bits and pointers are 0.
- Reset takes effect asynchronously mid-operation. In-flight and buffered results are discarded.
- Latency: p_valid at cycle N produces dout_valid=1 in cycle N+3 when the FIFO is empty and not blocked.
- Throughput: one result per cycle sustained while dout_ready=1.
- dout holds stable while dout_valid=1 and dout_ready=0.
- p_afull leads a full FIFO by at least one cycle. The sequencer must stop issuing p_valid the cycle after it sees p_afull.

## Configuration
- CNN_LAYER_ACCEL_MACC_OUT_RELU_EN defined: stage 3 forces negative results to 0 before saturation. Only positive saturation is then possible.
- CNN_LAYER_ACCEL_MACC_OUT_RELU_EN undefined: no ReLU. Signed output over the full range.

## Structure
- Shared package cnn_layer_accel_pkg holds:
  - the default width constants (C_P_WIDTH, C_OUT_WIDTH, C_SHIFT_WIDTH);
  - the saturation limits;
  - a typedef for the stage-2/3 pipeline record {valid, value, shift}.
- One sub-module: cnn_layer_accel_sync_fifo. It is a parameterised FWFT FIFO providing count, the full/empty flags and the pointer wrap.
- Round/shift/saturate stays inline in this block.

## Test plan
- p_in=1000, cfg_shift=4, dout_ready=1 → dout=63 exactly three cycles after p_valid.
- p_in=−1000, cfg_shift=4 → dout=−62 without the macro, 0 with it; sat_sticky stays 0.
- p_in=1048576, cfg_shift=4 → dout=32767, sat_sticky=1. Then clr_status with no new event → sat_sticky=0.
- cfg_shift=0, p_in=−40000 → dout=−32768 (no macro), sat_sticky=1.
- dout_ready=0, six back-to-back p_valid → 4 results stored and 2 dropped; fifo_count=4, ovf_sticky=1. p_afull asserts once occupancy plus in-flight reaches 3. Releasing dout_ready drains the first four results in order.
- Two entries buffered, rst pulsed mid-cycle → dout_valid=0 and fifo_count=0 immediately. The next p_valid emerges after 3 cycles.
